// File: rtl/driver_display_7seg_mux.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding a time-multiplexed
// N-digit 7-segment display with optional leading-zero blanking and overflow dashes.
module driver_display_7seg_mux #(
   parameter int W           = 8,
   parameter int N_DIG       = 3,
   parameter int DIV         = 50000,
   parameter int BLANK_ZEROS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     valor,
   input  logic             carregar,
   output logic             ocupado,
   output logic             pronto,
   output logic             estouro,
   output logic [6:0]       seg,
   output logic [N_DIG-1:0] anodo
);

   // Enough BCD digits for 2^W-1 and for every displayed digit.
   localparam int BIN_DIG = (W * 301) / 1000 + 1;
   localparam int BCD_DIG = (BIN_DIG > N_DIG) ? BIN_DIG : N_DIG;
   localparam int BCD_W   = 4 * BCD_DIG;
   localparam int CNT_W   = $clog2(W);
   localparam int PRE_W   = $clog2(DIV);
   localparam int IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) p = p * 32'd10;
      return p;
   endfunction

   localparam logic [31:0] LIMIT = pow10(N_DIG) - 32'd1;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < BCD_DIG; i++)
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      return r;
   endfunction

   function automatic logic [6:0] enc7(input logic [3:0] d);
      case (d)
         4'd0:    enc7 = 7'b1111110;
         4'd1:    enc7 = 7'b0110000;
         4'd2:    enc7 = 7'b1101101;
         4'd3:    enc7 = 7'b1111001;
         4'd4:    enc7 = 7'b0110011;
         4'd5:    enc7 = 7'b1011011;
         4'd6:    enc7 = 7'b1011111;
         4'd7:    enc7 = 7'b1110000;
         4'd8:    enc7 = 7'b1111111;
         4'd9:    enc7 = 7'b1111011;
         default: enc7 = 7'b0000000;
      endcase
   endfunction

   typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;

   estado_t              estado, estado_nx;
   logic [CNT_W-1:0]     cnt;
   logic [W-1:0]         bin_sh;
   logic [BCD_W-1:0]     bcd_acc;
   logic [BCD_W-1:0]     bcd_adj;
   logic [4*N_DIG-1:0]   disp;
   logic [PRE_W-1:0]     pre;
   logic [IDX_W-1:0]     idx;
   logic [3:0]           dig;
   logic                 hi_zero;
   logic [6:0]           seg_nx;

   always_ff @(posedge clk) begin
      if (rst) estado <= OCIOSO;
      else     estado <= estado_nx;
   end

   always_comb begin
      estado_nx = estado;
      ocupado   = 1'b0;
      pronto    = 1'b0;
      case (estado)
         OCIOSO:   if (carregar) estado_nx = CONVERTE;
         CONVERTE: begin
            ocupado = 1'b1;
            if (cnt == CNT_W'(W - 1)) estado_nx = ATUALIZA;
         end
         ATUALIZA: begin
            ocupado   = 1'b1;
            pronto    = 1'b1;
            estado_nx = OCIOSO;
         end
         default:  estado_nx = OCIOSO;
      endcase
   end

   assign bcd_adj = add3(bcd_acc);

   // Conversion datapath: no reset, every load re-initialises it.
   always_ff @(posedge clk) begin
      if (estado == OCIOSO && carregar) begin
         bin_sh  <= valor;
         bcd_acc <= '0;
         cnt     <= '0;
      end else if (estado == CONVERTE) begin
         bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sh[W-1]};
         bin_sh  <= {bin_sh[W-2:0], 1'b0};
         cnt     <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estouro <= 1'b0;
         disp    <= '0;
      end else begin
         if (estado == OCIOSO && carregar) estouro <= (32'(valor) > LIMIT);
         if (estado == ATUALIZA)           disp    <= bcd_acc[4*N_DIG-1:0];
      end
   end

   // A digit above 0 is blanked when it and every higher digit are zero.
   always_comb begin
      dig     = 4'd0;
      hi_zero = 1'b1;
      for (int k = 0; k < N_DIG; k++) begin
         if (IDX_W'(k) == idx) dig = disp[4*k +: 4];
         if (k >= int'(idx) && disp[4*k +: 4] != 4'd0) hi_zero = 1'b0;
      end
      seg_nx = enc7(dig);
      if (BLANK_ZEROS != 0 && idx != '0 && hi_zero) seg_nx = 7'b0000000;
      if (estouro) seg_nx = 7'b0000001;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre   <= '0;
         idx   <= '0;
         anodo <= '0;
         seg   <= '0;
      end else begin
         if (pre == PRE_W'(DIV - 1)) begin
            pre <= '0;
            if (idx == IDX_W'(N_DIG - 1)) idx <= '0;
            else                          idx <= idx + 1'b1;
         end else begin
            pre <= pre + 1'b1;
         end
         anodo <= N_DIG'(1) << idx;
         seg   <= seg_nx;
      end
   end

endmodule

// File: tb/tb_driver_display_7seg_mux.sv
// Directed bench: a 3-digit and a 2-digit instance (W=8, DIV=4) checked against
// hand-computed segment patterns, latencies and scan order.
module tb_driver_display_7seg_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] valor3, valor2;
   logic       carregar3, carregar2;
   logic       ocupado3, pronto3, estouro3;
   logic       ocupado2, pronto2, estouro2;
   logic [6:0] seg3, seg2;
   logic [2:0] anodo3;
   logic [1:0] anodo2;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                          S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                          S7 = 7'b1110000, S9 = 7'b1111011, BLK = 7'b0000000,
                          DASH = 7'b0000001;

   driver_display_7seg_mux #(.W(8), .N_DIG(3), .DIV(4), .BLANK_ZEROS(1)) dut3 (
      .clk(clk), .rst(rst), .valor(valor3), .carregar(carregar3),
      .ocupado(ocupado3), .pronto(pronto3), .estouro(estouro3),
      .seg(seg3), .anodo(anodo3)
   );

   driver_display_7seg_mux #(.W(8), .N_DIG(2), .DIV(4), .BLANK_ZEROS(1)) dut2 (
      .clk(clk), .rst(rst), .valor(valor2), .carregar(carregar2),
      .ocupado(ocupado2), .pronto(pronto2), .estouro(estouro2),
      .seg(seg2), .anodo(anodo2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int which, input logic [7:0] v);
      if (which == 3) begin valor3 = v; carregar3 = 1'b1; end
      else            begin valor2 = v; carregar2 = 1'b1; end
      tick();
      carregar3 = 1'b0;
      carregar2 = 1'b0;
   endtask

   // Returns the number of edges after the capture edge at which pronto is seen.
   task automatic wait_pronto(input int which, input int base, output int lat);
      int k;
      k   = base;
      lat = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         k++;
         if ((which == 3) ? pronto3 : pronto2) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic get_seg(input int which, input int k, output logic [6:0] s);
      logic [2:0] a;
      s = 7'bxxxxxxx;
      for (int i = 0; i < 40; i++) begin
         a = (which == 3) ? anodo3 : {1'b0, anodo2};
         if (a == 3'(1 << k)) begin
            s = (which == 3) ? seg3 : seg2;
            return;
         end
         tick();
      end
      chk("scan_timeout", 32'd0, 32'd1);
   endtask

   task automatic digit_chk(input int which, input int k, input logic [6:0] exp, input string tag);
      logic [6:0] s;
      get_seg(which, k, s);
      chk(tag, 32'(s), 32'(exp));
   endtask

   initial begin
      int         lat, occ, pcnt, pat, bad;
      logic [2:0] a, prev;

      rst = 1'b1; carregar3 = 1'b0; carregar2 = 1'b0; valor3 = '0; valor2 = '0;
      tick(); tick();
      chk("rst_anodo", 32'(anodo3), 32'd0);
      chk("rst_seg", 32'(seg3), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_anodo", 32'(anodo3), 32'd1);
      chk("post_rst_seg", 32'(seg3), 32'(S0));
      chk("post_rst_ocupado", 32'(ocupado3), 32'd0);
      chk("post_rst_estouro", 32'(estouro3), 32'd0);
      chk("post_rst_pronto", 32'(pronto3), 32'd0);
      chk("post_rst_anodo2", 32'(anodo2), 32'd1);

      // 237: ocupado for 9 cycles, pronto 8 edges after capture, old display held
      start(3, 8'd237);
      chk("estouro_237", 32'(estouro3), 32'd0);
      occ = 0; pcnt = 0; pat = -1; bad = 0;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) tick();
         if (ocupado3) occ++;
         if (pronto3) begin pcnt++; pat = k; end
         if (k <= 9 && seg3 !== ((anodo3 == 3'b001) ? S0 : BLK)) bad++;
      end
      chk("ocupado_len", 32'(occ), 32'd9);
      chk("pronto_count", 32'(pcnt), 32'd1);
      chk("pronto_at", 32'(pat), 32'd8);
      chk("no_glitch", 32'(bad), 32'd0);

      prev = anodo3;
      for (int i = 0; i < 20; i++) begin
         if (anodo3 != prev) break;
         tick();
      end
      a = anodo3;
      tick(); tick(); tick();
      chk("anodo_hold", 32'(anodo3), 32'(a));
      tick();
      a = {a[1:0], a[2]};
      chk("anodo_rot1", 32'(anodo3), 32'(a));
      tick(); tick(); tick(); tick();
      a = {a[1:0], a[2]};
      chk("anodo_rot2", 32'(anodo3), 32'(a));
      tick(); tick(); tick(); tick();
      a = {a[1:0], a[2]};
      chk("anodo_rot3", 32'(anodo3), 32'(a));
      digit_chk(3, 0, S7, "d237_0");
      digit_chk(3, 1, S3, "d237_1");
      digit_chk(3, 2, S2, "d237_2");

      // 5 with leading-zero blanking
      start(3, 8'd5);
      wait_pronto(3, 0, lat);
      chk("lat_5", 32'(lat), 32'd8);
      tick(); tick();
      digit_chk(3, 0, S5, "d5_0");
      digit_chk(3, 1, BLK, "d5_1");
      digit_chk(3, 2, BLK, "d5_2");

      // 2-digit instance: overflow then recovery
      start(2, 8'd150);
      chk("estouro_150", 32'(estouro2), 32'd1);
      wait_pronto(2, 0, lat);
      tick(); tick();
      digit_chk(2, 0, DASH, "d150_0");
      digit_chk(2, 1, DASH, "d150_1");
      start(2, 8'd42);
      chk("estouro_42", 32'(estouro2), 32'd0);
      wait_pronto(2, 0, lat);
      tick(); tick();
      digit_chk(2, 0, S2, "d42n2_0");
      digit_chk(2, 1, S4, "d42n2_1");

      // strobe during conversion is ignored
      start(3, 8'd99);
      tick(); tick();
      valor3 = 8'd1; carregar3 = 1'b1;
      tick();
      carregar3 = 1'b0;
      wait_pronto(3, 3, lat);
      chk("lat_99", 32'(lat), 32'd8);
      tick(); tick();
      digit_chk(3, 0, S9, "d99_0");
      digit_chk(3, 1, S9, "d99_1");
      digit_chk(3, 2, BLK, "d99_2");

      // idle strobe accepted; then strobe in the very first idle cycle
      start(3, 8'd1);
      chk("ocupado_1", 32'(ocupado3), 32'd1);
      wait_pronto(3, 0, lat);
      chk("lat_1", 32'(lat), 32'd8);
      tick();
      chk("idle_after_1", 32'(ocupado3), 32'd0);
      start(3, 8'd42);
      chk("ocupado_42", 32'(ocupado3), 32'd1);
      chk("shows_1", 32'(seg3), 32'((anodo3 == 3'b001) ? S1 : BLK));
      wait_pronto(3, 0, lat);
      chk("lat_42", 32'(lat), 32'd8);
      tick(); tick();
      digit_chk(3, 0, S2, "d42_0");
      digit_chk(3, 1, S4, "d42_1");
      digit_chk(3, 2, BLK, "d42_2");

      // reset mid-conversion aborts; new load right after converts normally
      start(3, 8'd200);
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ocupado", 32'(ocupado3), 32'd0);
      chk("abort_pronto", 32'(pronto3), 32'd0);
      chk("abort_anodo", 32'(anodo3), 32'd0);
      chk("abort_seg", 32'(seg3), 32'd0);
      start(3, 8'd200);
      chk("abort_show0_anodo", 32'(anodo3), 32'd1);
      chk("abort_show0_seg", 32'(seg3), 32'(S0));
      chk("ocupado_200", 32'(ocupado3), 32'd1);
      wait_pronto(3, 0, lat);
      chk("lat_200", 32'(lat), 32'd8);
      tick(); tick();
      digit_chk(3, 0, S0, "d200_0");
      digit_chk(3, 1, S0, "d200_1");
      digit_chk(3, 2, S2, "d200_2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/driver_display_7seg_mux.md
Name: driver_display_7seg_mux

Overview:
- Parametrised successor to the team's combinational BCD-to-7-segment decoding path.
- Accepts an unsigned binary value on a load strobe and converts it sequentially to BCD (shift-and-add-3, one bit per clock).
- Drives an N-digit common-segment display by time-multiplexing digit enables from a prescaled scan counter.
- Adds optional leading-zero blanking and overflow indication.
- Sits between datapath results and the board's 7-segment display pins.

Parameters:
- W, 8, width of binary input; legal range 4..20.
- N_DIG, 3, number of display digits; legal range 1..6, and 10^N_DIG-1 must be representable by the internal BCD width.
- DIV, 50000, clocks per digit scan slot; legal range >= 2.
- BLANK_ZEROS, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- valor  in  W  unsigned binary value to display.
- carregar  in  1  load strobe; sampled only when ocupado=0.
- ocupado  out  1  high while a conversion is in progress.
- pronto  out  1  one-cycle pulse when the new value reaches the display register.
- estouro  out  1  level: last loaded value > 10^N_DIG-1.
- seg  out  7  segments {a,b,c,d,e,f,g}; a is the MSB; 1 = segment lit.
- anodo  out  N_DIG  one-hot digit enable; 1 = digit on; bit 0 = least significant digit.

Behaviour:
- Reset (rst=1 at an edge, including mid-conversion):
  - Conversion aborts; FSM goes to OCIOSO.
  - ocupado=0, pronto=0, estouro=0.
  - Display register cleared to all-zero BCD.
  - Scan prescaler and digit index cleared to 0.
  - seg=0 and anodo=0 in the cycle after reset.
  - From the following cycle the display shows "0" on digit 0.
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
  - OCIOSO, carregar=1 at edge T:
    - capture valor;
    - estouro <= (valor > 10^N_DIG-1);
    - clear BCD accumulator and bit counter;
    - go to CONVERTE; ocupado=1 from T+1.
  - CONVERTE, each edge:
    - every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left by 1;
    - bit counter increments;
    - after exactly W shift cycles, go to ATUALIZA.
  - ATUALIZA, one cycle:
    - copy the BCD accumulator to the display register; pronto=1 for this cycle;
    - ocupado falls and the FSM returns to OCIOSO at the next edge.
  - Latency: carregar at edge T gives pronto high in cycle T+W+1; the display register is valid from T+W+2.
  - carregar while ocupado=1 is ignored; it is not queued.
  - carregar in the same cycle the FSM returns to OCIOSO is accepted.
- Display register is updated only in ATUALIZA; the previous value stays shown during conversion, with no glitch.
- Scanning, independent of the FSM:
  - prescaler counts 0..DIV-1 and wraps;
  - on wrap, the digit index advances modulo N_DIG (N_DIG-1 -> 0).
  - anodo is the registered one-hot of the digit index: one digit active, never two.
  - seg is registered in the same cycle as anodo and is always consistent with the digit shown.
- Segment encoding, seg = abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - BCD values 10..15 cannot occur; if forced, seg=0000000.
- Blanking: with BLANK_ZEROS=1, digit k>0 shows seg=0000000 when it and all higher digits are zero. anodo still pulses, so brightness stays constant.
- Overflow: while estouro=1, every digit shows only segment g (0000001). The BCD display register still loads the low N_DIG digits.

Test Plan:
- Reset with rst=1 for 2 cycles (DIV=4, N_DIG=3, W=8) -> anodo=000 and seg=0000000 the cycle after; then anodo=001, seg=1111110; ocupado=0, estouro=0.
- carregar=1 with valor=8'd237 -> ocupado=1 for 9 cycles, pronto pulse at T+9; scan shows digit0=7 (1110000), digit1=3 (1111001), digit2=2 (1101101); anodo cycles 001->010->100->001 every 4 clocks.
- valor=8'd5 with BLANK_ZEROS=1 -> digit0=1011011, digits 1 and 2 give seg=0000000 while their anodo bit is high.
- N_DIG=2, valor=8'd150 -> estouro=1 and all digits show 0000001; then load valor=8'd42 -> estouro=0, digits show 2 and 4.
- Load 8'd99, then pulse carregar with valor=8'd1 at T+3 -> second strobe ignored, display shows 99; strobe at T+9 (ocupado=0) -> accepted, display shows 1.
- Assert rst at T+4 of a conversion of 8'd200 -> no pronto pulse, display shows "0", and a new carregar next cycle converts normally.
